// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core: opcode values, opcode field position,
// the default reset PC and the fetch FSM state encoding.
package mips_pkg;

  localparam logic [5:0] R_TYPE = 6'h00;
  localparam logic [5:0] MULT   = 6'h01;
  localparam logic [5:0] BEQ    = 6'h04;
  localparam logic [5:0] BNE    = 6'h05;
  localparam logic [5:0] MOV    = 6'h06;
  localparam logic [5:0] ADDI   = 6'h08;
  localparam logic [5:0] ORI    = 6'h0d;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 26;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_HOLD = 2'd2
`ifdef IFETCH_MISALIGN_TRAP_EN
    , FETCH_HALT = 2'd3
`endif
  } fetch_state_t;

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO of {instr, pc} pairs with flush and simultaneous push/pop.
// Head entry is read straight from storage so a word pushed at an edge is visible after it.
module fetch_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [DATA_WIDTH-1:0]      push_instr,
  input  logic [DATA_WIDTH-1:0]      push_pc,
  input  logic                       pop,
  output logic [DATA_WIDTH-1:0]      head_instr,
  output logic [DATA_WIDTH-1:0]      head_pc,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] r_instr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_pc_mem    [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  w_do_push;
  logic                  w_do_pop;

  assign full       = (r_count == CW'(DEPTH));
  assign empty      = (r_count == '0);
  assign count      = r_count;
  assign w_do_push  = push && !full && !flush;
  assign w_do_pop   = pop && !empty && !flush;
  assign head_instr = r_instr_mem[r_rd_ptr];
  assign head_pc    = r_pc_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_instr_mem[r_wr_ptr] <= push_instr;
      r_pc_mem[r_wr_ptr]    <= push_pc;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, fetches over a req/ready handshake and buffers words for decode.
// Define IFETCH_MISALIGN_TRAP_EN to trap misaligned redirects (HALT state, fetch_error port).
module instruction_fetch
  import mips_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int                    BUF_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_ready,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  input  logic                  stall,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] instr_pc,
  output logic [5:0]            op
`ifdef IFETCH_MISALIGN_TRAP_EN
  , output logic                fetch_error
`endif
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  fetch_state_t          r_state;
  fetch_state_t          w_state_next;
  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] w_pc_next;
  logic [DATA_WIDTH-1:0] w_target;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_flush;
  logic                  w_full;
  logic                  w_empty;
  logic [CW-1:0]         w_count;
  logic [DATA_WIDTH-1:0] w_head_instr;
  logic [DATA_WIDTH-1:0] w_head_pc;

`ifdef IFETCH_MISALIGN_TRAP_EN
  logic r_fetch_error;
  logic w_fetch_error_next;
  logic w_misalign;
  assign w_misalign  = |redirect_pc[1:0];
  assign fetch_error = r_fetch_error;
`endif

  // Word-aligned branch target; the low bits are dropped when loading the PC.
  assign w_target = redirect_pc & ~DATA_WIDTH'(3);

  fetch_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (BUF_DEPTH)
  ) u_fetch_buffer (
    .clk        (clk),
    .reset      (reset),
    .flush      (w_flush),
    .push       (w_push),
    .push_instr (imem_rdata),
    .push_pc    (r_pc),
    .pop        (w_pop),
    .head_instr (w_head_instr),
    .head_pc    (w_head_pc),
    .full       (w_full),
    .empty      (w_empty),
    .count      (w_count)
  );

  assign imem_req    = (r_state == FETCH_REQ) && !w_full;
  assign imem_addr   = r_pc;
  assign instr_valid = !w_empty;
  assign instr       = instr_valid ? w_head_instr : '0;
  assign instr_pc    = instr_valid ? w_head_pc : '0;
  assign op          = instr[OP_MSB:OP_LSB];

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    w_flush      = 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
    w_fetch_error_next = r_fetch_error;
`endif
    if (redirect_valid) begin
      // Redirect wins: wrong-path words, any returning word and the decode accept are dropped.
      w_flush = 1'b1;
`ifdef IFETCH_MISALIGN_TRAP_EN
      if ((r_state == FETCH_HALT) || w_misalign) begin
        w_state_next       = FETCH_HALT;
        w_fetch_error_next = 1'b1;
      end else begin
        w_pc_next    = w_target;
        w_state_next = FETCH_REQ;
      end
`else
      w_pc_next    = w_target;
      w_state_next = FETCH_REQ;
`endif
    end else begin
      w_pop = instr_valid && !stall;
      case (r_state)
        FETCH_IDLE: w_state_next = FETCH_REQ;
        FETCH_REQ: begin
          if (imem_ready && !w_full) begin
            w_push    = 1'b1;
            w_pc_next = r_pc + DATA_WIDTH'(4);
            if (w_count + CW'(1) - CW'(w_pop) == CW'(BUF_DEPTH)) begin
              w_state_next = FETCH_HOLD;
            end
          end
        end
        FETCH_HOLD: begin
          if (w_pop) w_state_next = FETCH_REQ;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= FETCH_IDLE;
      r_pc    <= RESET_PC;
`ifdef IFETCH_MISALIGN_TRAP_EN
      r_fetch_error <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
`ifdef IFETCH_MISALIGN_TRAP_EN
      r_fetch_error <= w_fetch_error_next;
`endif
    end
  end

endmodule
